// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back block.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package wb_pkg;

  localparam int WB_WIDTH        = 32;
  localparam int WB_DEPTH        = 32;
  localparam int WB_LSU_DEPTH    = 2;
  localparam int WB_STARVE_LIMIT = 4;

  // Source of the write currently on the register file port (debug only).
  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LSU  = 2'd2
  } wb_src_e;

  // Pointer width for an n-entry buffer; a 1-entry buffer still needs a 1-bit pointer.
  function automatic int wb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of ALU/LSU result inputs, register file write port and decode read path.
// Latency: n/a (wires only).
// Backpressure: lsu_valid/lsu_ready handshake; alu_stall asks the ALU to hold off.
interface regfile_writeback_if import wb_pkg::*; #(
  parameter int WIDTH = WB_WIDTH,
  parameter int AW    = $clog2(WB_DEPTH)
) ();

  // ALU result port (no back-pressure, only a stall request)
  logic             alu_valid;
  logic [AW-1:0]    alu_rd;
  logic [WIDTH-1:0] alu_data;
  logic             alu_stall;

  // LSU load result port (valid/ready)
  logic             lsu_valid;
  logic             lsu_ready;
  logic [AW-1:0]    lsu_rd;
  logic [WIDTH-1:0] lsu_data;

  // Register file write port and status
  logic             we0;
  logic [AW-1:0]    wr_addr0;
  logic [WIDTH-1:0] wr_din0;
  logic [1:0]       wb_src;
  logic             wb_busy;

  // Decode read path
  logic [AW-1:0]    rd_addr0;
  logic [AW-1:0]    rd_addr1;
  logic [WIDTH-1:0] rf_dout0;
  logic [WIDTH-1:0] rf_dout1;
  logic [WIDTH-1:0] fwd_dout0;
  logic [WIDTH-1:0] fwd_dout1;

  // Upstream pipeline / register file side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output rd_addr0, rd_addr1, rf_dout0, rf_dout1,
    input  alu_stall, lsu_ready,
    input  we0, wr_addr0, wr_din0, wb_src, wb_busy,
    input  fwd_dout0, fwd_dout1
  );

  // Write-back block side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  rd_addr0, rd_addr1, rf_dout0, rf_dout1,
    output alu_stall, lsu_ready,
    output we0, wr_addr0, wr_din0, wb_src, wb_busy,
    output fwd_dout0, fwd_dout1
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding buffered LSU results ({rd, data}).
// Latency: pushed entry is visible at the head on the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; full/count exported.
module wb_fifo import wb_pkg::*; #(
  parameter  int W     = 37,
  parameter  int DEPTH = 2,
  localparam int PW    = wb_ptr_w(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage array; contents are don't-care until written so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap at DEPTH (DEPTH need not be a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and buffered LSU results into one registered register-file write; optional write->read forwarding (WB_FORWARD_EN).
// Latency: selected write appears on we0/wr_addr0/wr_din0 one cycle after selection; forwarding is combinational.
// Backpressure: lsu_ready = FIFO not full; alu_stall raised after STARVE_LIMIT lost cycles until the head drains.
module regfile_writeback import wb_pkg::*; #(
  parameter int WIDTH        = WB_WIDTH,
  parameter int DEPTH        = WB_DEPTH,
  parameter int LSU_DEPTH    = WB_LSU_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input logic               clk,
  input logic               rst,
  regfile_writeback_if.slave wb
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + WIDTH;
  localparam int CW = $clog2(LSU_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic             alu_wr;
  logic             lsu_push;
  logic             lsu_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [FW-1:0]    head;
  logic [AW-1:0]    head_rd;
  logic [WIDTH-1:0] head_dat;
  logic [SW-1:0]    starve_cnt;

  // x0 writes are architecturally void: they neither write nor block the LSU.
  assign alu_wr   = wb.alu_valid && (wb.alu_rd != '0);
  assign lsu_push = wb.lsu_valid && !fifo_full && (wb.lsu_rd != '0);
  assign lsu_pop  = !alu_wr && !fifo_empty;
  assign {head_rd, head_dat} = head;

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign wb.lsu_ready = !fifo_full;
  assign wb.wb_busy   = (fifo_count != '0);
  assign wb.alu_stall = (starve_cnt == SW'(STARVE_LIMIT));

  wb_fifo #(
    .W     (FW),
    .DEPTH (LSU_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (lsu_push),
    .push_dat ({wb.lsu_rd, wb.lsu_data}),
    .pop      (lsu_pop),
    .pop_dat  (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Registered write port: ALU has priority, then FIFO head, else idle with zeroed address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb.we0      <= 1'b0;
      wb.wr_addr0 <= '0;
      wb.wr_din0  <= '0;
      wb.wb_src   <= WB_SRC_NONE;
    end else if (alu_wr) begin
      wb.we0      <= 1'b1;
      wb.wr_addr0 <= wb.alu_rd;
      wb.wr_din0  <= wb.alu_data;
      wb.wb_src   <= WB_SRC_ALU;
    end else if (lsu_pop) begin
      wb.we0      <= 1'b1;
      wb.wr_addr0 <= head_rd;
      wb.wr_din0  <= head_dat;
      wb.wb_src   <= WB_SRC_LSU;
    end else begin
      wb.we0      <= 1'b0;
      wb.wr_addr0 <= '0;
      wb.wr_din0  <= '0;
      wb.wb_src   <= WB_SRC_NONE;
    end
  end

  // Starvation counter: counts cycles a waiting head loses to the ALU, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (lsu_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (alu_wr && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  // Bypass the write landing this edge onto the decode read data; x0 always reads the file.
  assign wb.fwd_dout0 = (wb.we0 && (wb.wr_addr0 == wb.rd_addr0) && (wb.rd_addr0 != '0))
                        ? wb.wr_din0 : wb.rf_dout0;
  assign wb.fwd_dout1 = (wb.we0 && (wb.wr_addr0 == wb.rd_addr1) && (wb.rd_addr1 != '0))
                        ? wb.wr_din0 : wb.rf_dout1;
`else
  // No bypass: decode sees the register file read data unchanged.
  assign wb.fwd_dout0 = wb.rf_dout0;
  assign wb.fwd_dout1 = wb.rf_dout1;
`endif

  a_no_x0_write: assert property (@(posedge clk) disable iff (rst) wb.we0 |-> (wb.wr_addr0 != '0));

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model predicts the registered write one cycle after the inputs are sampled.
// Backpressure: stimulus honours alu_stall as predicted by the model.
module tb_regfile_writeback;
  import wb_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int LSU_DEPTH = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_writeback_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  regfile_writeback #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LSU_DEPTH(LSU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending loads, the write seen on the port, and a lost-cycle tally.
  typedef struct packed {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] dat;
  } ent_t;

  ent_t             mq[$];
  int               lost;
  bit               m_we;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_din;
  int               m_src;

  always @(posedge clk) begin : model
    int   sz;
    ent_t e;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      lost = 0; m_we = 0; m_addr = '0; m_din = '0; m_src = 0;
    end else begin
      if (bus.alu_valid && bus.alu_rd != 0) begin
        m_we = 1; m_addr = bus.alu_rd; m_din = bus.alu_data; m_src = 1;
        if (sz > 0) lost = lost + 1;
      end else if (sz > 0) begin
        e = mq.pop_front();
        m_we = 1; m_addr = e.rd; m_din = e.dat; m_src = 2;
        lost = 0;
      end else begin
        m_we = 0; m_addr = '0; m_din = '0; m_src = 0;
      end
      if (sz == 0) lost = 0;
      if (bus.lsu_valid && sz < LSU_DEPTH && bus.lsu_rd != 0)
        mq.push_back('{rd: bus.lsu_rd, dat: bus.lsu_data});
    end
  end

  function automatic logic [WIDTH-1:0] exp_fwd(input logic [AW-1:0] ra, input logic [WIDTH-1:0] rf);
`ifdef WB_FORWARD_EN
    if (m_we && m_addr == ra && ra != 0) return m_din;
`endif
    return rf;
  endfunction

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("we0", bus.we0, m_we);
      cmp("wb_src", bus.wb_src, m_src);
      if (m_we) begin
        cmp("wr_addr0", bus.wr_addr0, m_addr);
        cmp("wr_din0", bus.wr_din0, m_din);
      end
      cmp("lsu_ready", bus.lsu_ready, mq.size() < LSU_DEPTH);
      cmp("wb_busy", bus.wb_busy, mq.size() != 0);
      cmp("alu_stall", bus.alu_stall, lost >= STARVE_LIMIT);
      cmp("fwd_dout0", bus.fwd_dout0, exp_fwd(bus.rd_addr0, bus.rf_dout0));
      cmp("fwd_dout1", bus.fwd_dout1, exp_fwd(bus.rd_addr1, bus.rf_dout1));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input logic [AW-1:0] ard, input logic [WIDTH-1:0] adat,
                       input bit lv, input logic [AW-1:0] lrd, input logic [WIDTH-1:0] ldat);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ldat;
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    int alu_pct;
    idle();
    bus.rd_addr0 = '0; bus.rd_addr1 = '0; bus.rf_dout0 = '0; bus.rf_dout1 = '0;
    rst = 1'b1;
    step(); step();
    chk_en = 1'b1;

    // Reset state
    cmp("rst_we0", bus.we0, 1'b0);
    cmp("rst_addr", bus.wr_addr0, 5'd0);
    cmp("rst_din", bus.wr_din0, 32'd0);
    cmp("rst_src", bus.wb_src, 2'd0);
    cmp("rst_stall", bus.alu_stall, 1'b0);
    cmp("rst_ready", bus.lsu_ready, 1'b1);
    cmp("rst_busy", bus.wb_busy, 1'b0);
    rst = 1'b0;

    // ALU only
    drive(1, 5'd5, 32'hDEADBEEF, 0, '0, '0); step();
    cmp("t1_we0", bus.we0, 1'b1);
    cmp("t1_addr", bus.wr_addr0, 5'd5);
    cmp("t1_din", bus.wr_din0, 32'hDEADBEEF);
    cmp("t1_src", bus.wb_src, 2'd1);

    // x0 drop from both sources
    drive(1, 5'd0, 32'h11, 1, 5'd0, 32'h22); step();
    cmp("t2_we0", bus.we0, 1'b0);
    cmp("t2_busy", bus.wb_busy, 1'b0);
    cmp("t2_ready", bus.lsu_ready, 1'b1);
    idle(); step();
    cmp("t2_we0_late", bus.we0, 1'b0);

    // ALU/LSU conflict in one cycle
    drive(1, 5'd3, 32'hA3, 1, 5'd7, 32'hB7); step();
    cmp("t3_src_a", bus.wb_src, 2'd1);
    cmp("t3_addr_a", bus.wr_addr0, 5'd3);
    idle(); step();
    cmp("t3_src_b", bus.wb_src, 2'd2);
    cmp("t3_addr_b", bus.wr_addr0, 5'd7);
    cmp("t3_din_b", bus.wr_din0, 32'hB7);
    idle(); step();
    cmp("t3_we0_idle", bus.we0, 1'b0);

    // Back-pressure and starvation
    drive(1, 5'd1, 32'h100, 1, 5'd10, 32'hAAAA); step();
    cmp("t4_busy", bus.wb_busy, 1'b1);
    drive(1, 5'd1, 32'h101, 1, 5'd11, 32'hBBBB); step();
    cmp("t4_ready_full", bus.lsu_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd1, 32'h102 + i, 1, 5'd12, 32'hCCCC); step();
      cmp("t4_stall", bus.alu_stall, (i == 2));
    end
    drive(0, '0, '0, 1, 5'd12, 32'hCCCC); step();
    cmp("t4_pop_a", bus.wr_din0, 32'hAAAA);
    cmp("t4_pop_a_src", bus.wb_src, 2'd2);
    cmp("t4_stall_fall", bus.alu_stall, 1'b0);
    cmp("t4_ready_back", bus.lsu_ready, 1'b1);
    drive(0, '0, '0, 1, 5'd12, 32'hCCCC); step();
    cmp("t4_pop_b", bus.wr_din0, 32'hBBBB);
    idle(); step();
    cmp("t4_pop_c", bus.wr_din0, 32'hCCCC);
    cmp("t4_drained", bus.wb_busy, 1'b0);

    // Reset mid-operation discards buffered results
    drive(1, 5'd2, 32'h1, 1, 5'd20, 32'h2020); step();
    drive(1, 5'd2, 32'h2, 1, 5'd21, 32'h2121); step();
    cmp("t5_full", bus.lsu_ready, 1'b0);
    idle(); rst = 1'b1; step();
    rst = 1'b0;
    cmp("t5_we0", bus.we0, 1'b0);
    cmp("t5_addr", bus.wr_addr0, 5'd0);
    cmp("t5_din", bus.wr_din0, 32'd0);
    cmp("t5_busy", bus.wb_busy, 1'b0);
    step();
    cmp("t5_never_written", bus.we0, 1'b0);

    // Forwarding of the in-flight write
    drive(1, 5'd9, 32'h1234, 0, '0, '0); step();
    bus.rd_addr1 = 5'd9; bus.rf_dout1 = 32'hCAFE;
    bus.rd_addr0 = 5'd0; bus.rf_dout0 = 32'h5A5A;
    #1;
`ifdef WB_FORWARD_EN
    cmp("t6_fwd1", bus.fwd_dout1, 32'h1234);
`else
    cmp("t6_fwd1", bus.fwd_dout1, 32'hCAFE);
`endif
    cmp("t6_fwd0_x0", bus.fwd_dout0, 32'h5A5A);
    idle();

    // Randomized traffic, alternating light and heavy ALU load
    for (int i = 0; i < 3000; i++) begin
      alu_pct = ((i / 400) % 2 == 1) ? 95 : 40;
      rst = ($urandom_range(0, 299) == 0);
      bus.alu_valid = ($urandom_range(0, 99) < alu_pct) && !(lost >= STARVE_LIMIT);
      bus.alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, DEPTH - 1));
      bus.alu_data  = $urandom;
      bus.lsu_valid = ($urandom_range(0, 99) < 50);
      bus.lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, DEPTH - 1));
      bus.lsu_data  = $urandom;
      bus.rd_addr0  = ($urandom_range(0, 1) == 0) ? m_addr : AW'($urandom_range(0, DEPTH - 1));
      bus.rd_addr1  = ($urandom_range(0, 1) == 0) ? m_addr : AW'($urandom_range(0, DEPTH - 1));
      bus.rf_dout0  = $urandom;
      bus.rf_dout1  = $urandom;
      step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
